// File: rtl/compare_pkg.sv
// Shared types for the bit-serial magnitude comparator: FSM states and the
// less/great/equal flag triple that travels between the slice and the registers.
package compare_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

  typedef struct packed {
    logic less;
    logic great;
    logic equal;
  } flags_t;

  // Flags before any bit has been examined: operands considered equal so far.
  localparam flags_t FlagsInit = '{less: 1'b0, great: 1'b0, equal: 1'b1};

endpackage

// File: rtl/one_bit_comparator.sv
// Combinational one-bit magnitude-compare slice, chained MSB-first through
// the incoming flags: once a difference is seen the verdict is passed through.
module one_bit_comparator
  import compare_pkg::*;
(
  input  logic   a,
  input  logic   b,
  input  flags_t flags_in,
  output flags_t flags_out
);

  always_comb begin
    flags_out = flags_in;
    if (flags_in.equal) begin
      flags_out.less  = ~a & b;
      flags_out.great = a & ~b;
      flags_out.equal = ~(a ^ b);
    end
  end

endmodule

// File: rtl/serial_compare_ctrl.sv
// Bit-serial magnitude-compare sequencer: walks one one_bit_comparator slice
// across two captured operands MSB-first, one bit per clock.
module serial_compare_ctrl
  import compare_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter bit          EARLY_EXIT = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       abort,
  input  logic [WIDTH-1:0]           a,
  input  logic [WIDTH-1:0]           b,
  output logic                       busy,
  output logic                       done,
  output logic                       less,
  output logic                       great,
  output logic                       equal,
  output logic [$clog2(WIDTH+1)-1:0] bits_used
);

  localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned CntW = $clog2(WIDTH + 1);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, b_q;
  flags_t            flags_q, slice_out, result_q;
  logic [IdxW-1:0]   idx_q;
  logic [CntW-1:0]   cnt_q, cnt_inc, bits_used_q;
  logic              accept, stepping, last_step;

  one_bit_comparator u_slice (
    .a         (a_q[idx_q]),
    .b         (b_q[idx_q]),
    .flags_in  (flags_q),
    .flags_out (slice_out)
  );

  assign accept    = (state_q == StIdle) && start;
  assign stepping  = (state_q == StShift) && !abort;
  assign cnt_inc   = (cnt_q == CntW'(WIDTH)) ? cnt_q : cnt_q + 1'b1;
  assign last_step = (idx_q == '0) || (EARLY_EXIT && !slice_out.equal);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (start) state_d = StShift;
      end
      StShift: begin
        if (abort) begin
          state_d = StIdle;
        end else if (last_step) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    busy      = (state_q != StIdle);
    done      = (state_q == StDone);
    less      = result_q.less;
    great     = result_q.great;
    equal     = result_q.equal;
    bits_used = bits_used_q;
  end

  // Operand, flag, counter and result registers. Results load on the edge
  // that enters DONE so they are already valid while done is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q         <= '0;
      b_q         <= '0;
      flags_q     <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      result_q    <= FlagsInit;
      bits_used_q <= '0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b;
      flags_q <= FlagsInit;
      idx_q   <= IdxW'(WIDTH - 1);
      cnt_q   <= '0;
    end else if (stepping) begin
      flags_q <= slice_out;
      idx_q   <= idx_q - 1'b1;
      cnt_q   <= cnt_inc;
      if (last_step) begin
        result_q    <= slice_out;
        bits_used_q <= cnt_inc;
      end
    end
  end

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Scoreboard bench for serial_compare_ctrl: one early-exit and one full-walk
// instance, expectations from plain integer comparison of the operands.
module tb_serial_compare_ctrl;

  localparam int W  = 8;
  localparam int BW = $clog2(W + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [W-1:0] a = '0, b = '0;
  logic start_e = 1'b0, abort_e = 1'b0, start_f = 1'b0, abort_f = 1'b0;
  logic busy_e, done_e, less_e, great_e, equal_e;
  logic busy_f, done_f, less_f, great_f, equal_f;
  logic [BW-1:0] bits_e, bits_f;

  serial_compare_ctrl #(.WIDTH(W), .EARLY_EXIT(1'b1)) dut_e (
    .clk(clk), .rst_n(rst_n), .start(start_e), .abort(abort_e), .a(a), .b(b),
    .busy(busy_e), .done(done_e), .less(less_e), .great(great_e), .equal(equal_e),
    .bits_used(bits_e)
  );

  serial_compare_ctrl #(.WIDTH(W), .EARLY_EXIT(1'b0)) dut_f (
    .clk(clk), .rst_n(rst_n), .start(start_f), .abort(abort_f), .a(a), .b(b),
    .busy(busy_f), .done(done_f), .less(less_f), .great(great_f), .equal(equal_f),
    .bits_used(bits_f)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic l;
    logic g;
    logic e;
    int   bits;
    int   cyc;
  } exp_t;

  exp_t q_e[$];
  exp_t q_f[$];
  exp_t last_e = '{l: 1'b0, g: 1'b0, e: 1'b1, bits: 0, cyc: 0};
  exp_t last_f = '{l: 1'b0, g: 1'b0, e: 1'b1, bits: 0, cyc: 0};

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic cmp_item(input string tag, input exp_t x, input logic l, input logic g,
                          input logic e, input int bits);
    check({tag, " done cycle"}, cycle, x.cyc);
    check({tag, " less"}, int'(l), int'(x.l));
    check({tag, " great"}, int'(g), int'(x.g));
    check({tag, " equal"}, int'(e), int'(x.e));
    check({tag, " bits_used"}, bits, x.bits);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t x;
    if (rst_n) begin
      if (done_e) begin
        if (q_e.size() == 0) check("e unexpected done", 1, 0);
        else begin
          x = q_e.pop_front();
          cmp_item("e", x, less_e, great_e, equal_e, int'(bits_e));
          last_e = x;
        end
      end
      if (done_f) begin
        if (q_f.size() == 0) check("f unexpected done", 1, 0);
        else begin
          x = q_f.pop_front();
          cmp_item("f", x, less_f, great_f, equal_f, int'(bits_f));
          last_f = x;
        end
      end
    end
  end

  // Steps taken: full walk, or MSB-first position of the first differing bit.
  function automatic int model_n(input logic [W-1:0] x, input logic [W-1:0] y, input bit early);
    if (!early) return W;
    for (int i = W - 1; i >= 0; i--) begin
      if (x[i] != y[i]) return W - i;
    end
    return W;
  endfunction

  // Called at posedge+1; start is sampled at the next edge.
  task automatic go(input bit full, input logic [W-1:0] av, input logic [W-1:0] bv,
                    input bit push, output int exp_cyc);
    exp_t x;
    int n;
    n      = model_n(av, bv, !full);
    x.l    = (av < bv);
    x.g    = (av > bv);
    x.e    = (av == bv);
    x.bits = n;
    x.cyc  = cycle + 1 + n;
    exp_cyc = x.cyc;
    if (push) begin
      if (full) q_f.push_back(x);
      else q_e.push_back(x);
    end
    a = av;
    b = bv;
    if (full) start_f = 1'b1;
    else start_e = 1'b1;
    @(posedge clk); #1;
    start_f = 1'b0;
    start_e = 1'b0;
  endtask

  task automatic wait_idle(input bit full);
    int k = 0;
    while (k < 60 && (full ? (q_f.size() != 0 || busy_f) : (q_e.size() != 0 || busy_e))) begin
      @(posedge clk); #1;
      k++;
    end
    check(full ? "f reaches idle" : "e reaches idle", int'(k < 60), 1);
  endtask

  task automatic check_reset(input string tag);
    check({tag, " busy_e"}, int'(busy_e), 0);
    check({tag, " done_e"}, int'(done_e), 0);
    check({tag, " flags_e"}, int'({less_e, great_e, equal_e}), 1);
    check({tag, " bits_e"}, int'(bits_e), 0);
    check({tag, " busy_f"}, int'(busy_f), 0);
    check({tag, " flags_f"}, int'({less_f, great_f, equal_f}), 1);
    check({tag, " bits_f"}, int'(bits_f), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected < 20000", cycle);
    $fatal(1);
  end

  initial begin
    int c, c2;
    logic [W-1:0] x, y;

    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    go(1'b0, 8'h5A, 8'h5A, 1'b1, c); wait_idle(1'b0);
    go(1'b0, 8'h80, 8'h7F, 1'b1, c); wait_idle(1'b0);
    go(1'b1, 8'h10, 8'h11, 1'b1, c); wait_idle(1'b1);

    // Abort mid-SHIFT: no done, results held
    go(1'b0, 8'h03, 8'h05, 1'b0, c);
    abort_e = 1'b1;
    @(posedge clk); #1;
    abort_e = 1'b0;
    check("abort busy", int'(busy_e), 0);
    check("abort flags held", int'({less_e, great_e, equal_e}),
          int'({last_e.l, last_e.g, last_e.e}));
    check("abort bits held", int'(bits_e), last_e.bits);
    repeat (10) begin @(posedge clk); #1; end
    go(1'b0, 8'h05, 8'h03, 1'b1, c); wait_idle(1'b0);

    // start and abort together in IDLE: start wins
    abort_f = 1'b1;
    go(1'b1, 8'h21, 8'h20, 1'b1, c);
    abort_f = 1'b0;
    wait_idle(1'b1);

    // start while busy is ignored; back-to-back start right after done
    go(1'b0, 8'h01, 8'h00, 1'b1, c);
    repeat (4) begin
      a = W'($urandom);
      b = W'($urandom);
      start_e = 1'b1;
      @(posedge clk); #1;
    end
    start_e = 1'b0;
    check("busy while ignoring start", int'(busy_e), 1);
    while (cycle < c + 1) begin @(posedge clk); #1; end
    go(1'b0, 8'h3C, 8'hC3, 1'b1, c2);
    check("back-to-back spacing", c2 - c, 2 + model_n(8'h3C, 8'hC3, 1'b1));
    wait_idle(1'b0);

    // Reset mid-SHIFT
    go(1'b1, 8'hAA, 8'h55, 1'b0, c);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_reset("mid reset");
    last_e = '{l: 1'b0, g: 1'b0, e: 1'b1, bits: 0, cyc: 0};
    last_f = '{l: 1'b0, g: 1'b0, e: 1'b1, bits: 0, cyc: 0};
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    go(1'b1, 8'hAA, 8'h55, 1'b1, c); wait_idle(1'b1);

    // Random operands, biased towards equal and near-equal pairs
    repeat (30) begin
      x = W'($urandom);
      case ($urandom_range(0, 3))
        0:       y = x;
        1:       y = x ^ W'(1 << $urandom_range(0, W - 1));
        default: y = W'($urandom);
      endcase
      go(1'b0, x, y, 1'b1, c); wait_idle(1'b0);
      go(1'b1, x, y, 1'b1, c); wait_idle(1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
